pulse_stretcher: RTL and testbench

// Inverse of the button pulse generator: turns single-cycle event pulses back into level

---
 rtl/pulse_stretcher.sv | 142 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length high windows separated by a
// minimum low gap; events arriving mid-window are queued in a saturating counter.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             pulse_i,
  input  logic                             clr_i,
  output logic                             level_o,
  output logic                             busy_o,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_o,
  output logic                             overflow_o
);

  localparam int PW      = $clog2(MAX_PENDING + 1);
  localparam int DUR_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(DUR_MAX + 1);

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   dur_cnt;
  logic [CW-1:0]   dur_next;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   pending_next;
  logic            overflow;
  logic            overflow_next;
  logic            dur_last;
  logic            inc;
  logic            dec;
  logic            drop;

  // Saturating queue update; a simultaneous increment and decrement cancel out.
  function automatic logic [PW-1:0] pend_update(input logic [PW-1:0] cur,
                                                input logic          up,
                                                input logic          down);
    logic [PW-1:0] res;
    res = cur;
    if (up && !down) begin
      res = (cur == PEND_FULL) ? cur : cur + 1'b1;
    end else if (down && !up) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  assign dur_last = (dur_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      dur_cnt  <= dur_next;
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

  // The counter holds remaining cycles minus one, so it reloads on entry and stops at zero.
  always_comb begin
    state_next = state;
    dur_next   = dur_cnt;
    inc        = 1'b0;
    dec        = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_i) begin
          state_next = HIGH;
          dur_next   = HIGH_LOAD;
        end
      end
      HIGH: begin
        inc = pulse_i;
        if (dur_last) begin
          state_next = GAP;
          dur_next   = GAP_LOAD;
        end else begin
          dur_next = dur_cnt - 1'b1;
        end
      end
      GAP: begin
        if (dur_last) begin
          if (pending != '0) begin
            inc        = pulse_i;
            dec        = 1'b1;
            state_next = HIGH;
            dur_next   = HIGH_LOAD;
          end else if (pulse_i) begin
            // Empty queue: a pulse here behaves like a fresh start from IDLE.
            state_next = HIGH;
            dur_next   = HIGH_LOAD;
          end else begin
            state_next = IDLE;
            dur_next   = '0;
          end
        end else begin
          inc      = pulse_i;
          dur_next = dur_cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        dur_next   = '0;
      end
    endcase
  end

  always_comb begin
    drop          = inc && !dec && (pending == PEND_FULL);
    pending_next  = pend_update(pending, inc, dec);
    overflow_next = overflow;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clr_i) begin
      overflow_next = 1'b0;
    end
  end

  always_comb begin
    level_o    = (state == HIGH);
    busy_o     = (state != IDLE);
    pending_o  = pending;
    overflow_o = overflow;
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: per-edge expected outputs are queued by the driver
// and compared by an independent monitor on the falling edge.
module tb_pulse_stretcher;

  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pulse;
  logic          clr;
  logic          level;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  typedef struct {
    string         tag;
    logic          lvl;
    logic          bsy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pulse_stretcher #(
    .HIGH_CYCLES(4),
    .GAP_CYCLES (2),
    .MAX_PENDING(3)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .pulse_i   (pulse),
    .clr_i     (clr),
    .level_o   (level),
    .busy_o    (busy),
    .pending_o (pending),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string fld, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s got %0d want %0d", tag, fld, act, exp);
    end
  endtask

  function automatic logic bit_at(input string s, input int i);
    return (i < s.len()) && (s.getc(i) == "1");
  endfunction

  // Each character index is one rising edge: inputs sampled there, outputs expected after it.
  // st: H=high window, G=gap, I=idle; pend: digit; ovf: 1/0 (missing chars mean 0).
  task automatic run_vec(input string name, input string pul, input string clrs,
                         input string st, input string pend, input string ovf);
    for (int i = 0; i < st.len(); i++) begin
      exp_t e;
      pulse = bit_at(pul, i);
      clr   = bit_at(clrs, i);
      @(posedge clk);
      #1;
      e.tag  = $sformatf("%s[%0d]", name, i);
      e.lvl  = (st.getc(i) == "H");
      e.bsy  = (st.getc(i) != "I");
      e.pend = PW'(int'(pend.getc(i)) - 48);
      e.ovf  = bit_at(ovf, i);
      sb_q.push_back(e);
      @(negedge clk);
    end
    pulse = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, "queue_left", sb_q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, "level",    int'(level),    int'(e.lvl));
        check(e.tag, "busy",     int'(busy),     int'(e.bsy));
        check(e.tag, "pending",  int'(pending),  int'(e.pend));
        check(e.tag, "overflow", int'(overflow), int'(e.ovf));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    pulse = 1'b0;
    clr   = 1'b0;
    #12;
    check("reset", "level",    int'(level),    0);
    check("reset", "busy",     int'(busy),     0);
    check("reset", "pending",  int'(pending),  0);
    check("reset", "overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec("t1_single", "1", "", "HHHHGGII", "00000000", "");
    run_vec("t2_three", "111", "",
            "HHHHGGHHHHGGHHHHGGII",
            "01222211111100000000", "");
    run_vec("t3_sat", "11111", "0000000000000000000000001",
            "HHHHGGHHHHGGHHHHGGHHHHGGII",
            "01233322222211111100000000",
            "00001111111111111111111100");
    run_vec("t4_lastgap_pend", "1100001", "",
            "HHHHGGHHHHGGHHHHGGII",
            "01111111111100000000", "");
    run_vec("t4_lastgap_empty", "1000001", "",
            "HHHHGGHHHHGGII",
            "00000000000000", "");
    run_vec("t4_midgap", "100001", "",
            "HHHHGGHHHHGGII",
            "00000100000000", "");
    run_vec("t6_set_vs_clr", "11111", "000011",
            "HHHHGGHHHHGGHHHHGGHHHHGGII",
            "01233322222211111100000000",
            "00001");
    drain("t6_drain");

    run_vec("t5_setup", "11111", "", "HHHHGGH", "0123332", "0000111");
    drain("t5_drain");
    check("t5_pre_rst", "level",    int'(level),    1);
    check("t5_pre_rst", "overflow", int'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", "level",    int'(level),    0);
    check("t5_async_rst", "busy",     int'(busy),     0);
    check("t5_async_rst", "pending",  int'(pending),  0);
    check("t5_async_rst", "overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("t5_after", "1", "", "HHHHGGII", "00000000", "");
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
